// File: rtl/gray2rgb_pkg.sv
// Shared types and palette defaults for the gray-to-RGB pseudo-colour expander.
package gray2rgb_pkg;

    typedef logic [11:0] pix12_t;
    typedef logic [3:0]  lvl_t;

    localparam int unsigned PAL_DEPTH = 16;

    function automatic pix12_t default_pal(input lvl_t i);
        return {i, i, i};
    endfunction

endpackage

// File: rtl/gray2rgb_pal_rf.sv
// 16x12 palette register file: one write port, two asynchronous read ports.
module gray2rgb_pal_rf
    import gray2rgb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [11:0] wdata,
    input  logic [3:0]  raddr_a,
    output logic [11:0] rdata_a,
    input  logic [3:0]  raddr_b,
    output logic [11:0] rdata_b
);

    pix12_t mem [PAL_DEPTH];

    // Each entry resets to identity gray so an unprogrammed palette is transparent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
                mem[i] <= default_pal(lvl_t'(i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/gray2rgb_pal.sv
// Streaming pseudo-colour expander: 2-stage elastic pipeline mapping gray level
// in_pix[11:8] through a programmable palette, with registered palette readback.
module gray2rgb_pal
    import gray2rgb_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int LVL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pal_we,
    input  logic [LVL_W-1:0] pal_addr,
    input  logic [PIX_W-1:0] pal_wdata,
    output logic [PIX_W-1:0] pal_rdata,
    input  logic             color_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_last
);

    if (PIX_W != 12 || LVL_W != 4) begin : g_bad_param
        $error("gray2rgb_pal supports only PIX_W=12 and LVL_W=4");
    end

    logic   s1_v;
    lvl_t   s1_idx;
    pix12_t s1_pix;
    logic   s1_cen;
    logic   s1_last;

    logic   s2_v;
    pix12_t s2_pix;
    logic   s2_last;

    pix12_t pal_pix;
    pix12_t pal_rb;

    logic   s2_ready;
    logic   s1_load;
    logic   s2_load;

    gray2rgb_pal_rf u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (pal_we),
        .waddr   (pal_addr),
        .wdata   (pal_wdata),
        .raddr_a (s1_idx),
        .rdata_a (pal_pix),
        .raddr_b (pal_addr),
        .rdata_b (pal_rb)
    );

    always_comb begin
        s2_ready = !s2_v || out_ready;
        in_ready = !s1_v || s2_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_v && s2_ready;
    end

    // Palette lookup is combinational from s1, so a write on the advancing edge
    // lands after the read and is only seen by later pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_idx    <= '0;
            s1_pix    <= '0;
            s1_cen    <= 1'b0;
            s1_last   <= 1'b0;
            s2_v      <= 1'b0;
            s2_pix    <= '0;
            s2_last   <= 1'b0;
            pal_rdata <= '0;
        end else begin
            if (s1_load) begin
                s1_v    <= 1'b1;
                s1_idx  <= in_pix[11:8];
                s1_pix  <= in_pix;
                s1_cen  <= color_en;
                s1_last <= in_last;
            end else if (s2_load) begin
                s1_v    <= 1'b0;
            end

            if (s2_load) begin
                s2_v    <= 1'b1;
                s2_pix  <= s1_cen ? pal_pix : s1_pix;
                s2_last <= s1_last;
            end else if (out_ready) begin
                s2_v    <= 1'b0;
            end

            pal_rdata <= pal_rb;
        end
    end

    assign out_valid = s2_v;
    assign out_pix   = s2_pix;
    assign out_last  = s2_last;

endmodule

// File: tb/tb_gray2rgb_pal.sv
// Directed self-checking bench for gray2rgb_pal.
module tb_gray2rgb_pal;

    logic        clk;
    logic        rst_n;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [11:0] pal_rdata;
    logic        color_en;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_pix;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pix;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    gray2rgb_pal #(.PIX_W(12), .LVL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .pal_rdata (pal_rdata),
        .color_en  (color_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
        color_en = 1'b1; in_valid = 1'b0; in_pix = '0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pix !== 12'h000) begin errors++; $display("FAIL reset_out_pix: got %h expected 000", out_pix); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (pal_rdata !== 12'h000) begin errors++; $display("FAIL reset_pal_rdata: got %h expected 000", pal_rdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_colour();
        logic [11:0] pix [3];
        logic [11:0] exp [3];
        pix = '{12'h000, 12'h555, 12'hFFF};
        exp = '{12'h000, 12'h555, 12'hFFF};
        color_en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            if (c < 3) in_pix = pix[c];
            #1;
            checks++;
            if (out_valid !== (c >= 2 && c < 5)) begin
                errors++; $display("FAIL default_valid c=%0d: got %b expected %b", c, out_valid, (c >= 2 && c < 5));
            end
            if (c >= 2 && c < 5) begin
                checks++;
                if (out_pix !== exp[c-2]) begin errors++; $display("FAIL default_pix c=%0d: got %h expected %h", c, out_pix, exp[c-2]); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int          send [10];
        logic        rdy  [7];
        logic [11:0] pix  [5];
        pix  = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        send = '{0, 1, 2, 2, 2, 3, 4, -1, -1, -1};
        rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        color_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 4);
            in_valid  = (send[c] >= 0);
            if (send[c] >= 0) in_pix = pix[send[c]];
            in_last   = (send[c] == 4);
            #1;
            if (c < 7) begin
                checks++;
                if (in_ready !== rdy[c]) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, in_ready, rdy[c]); end
            end
            checks++;
            if (out_valid !== (c >= 2 && c < 9)) begin
                errors++; $display("FAIL bp_valid c=%0d: got %b expected %b", c, out_valid, (c >= 2 && c < 9));
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (out_pix !== 12'h111) begin errors++; $display("FAIL bp_stall_pix c=%0d: got %h expected 111", c, out_pix); end
            end
            if (c >= 4 && c < 9) begin
                checks++;
                if (out_pix !== pix[c-4]) begin errors++; $display("FAIL bp_drain_pix c=%0d: got %h expected %h", c, out_pix, pix[c-4]); end
                checks++;
                if (out_last !== (c == 8)) begin errors++; $display("FAIL bp_last c=%0d: got %b expected %b", c, out_last, (c == 8)); end
            end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_collision();
        logic [11:0] exp [2];
        exp = '{12'h555, 12'h0F0};
        color_en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid  = (c < 2);
            in_pix    = 12'h555;
            pal_we    = (c == 1);
            pal_addr  = 4'd5;
            pal_wdata = 12'h0F0;
            #1;
            checks++;
            if (out_valid !== (c == 2 || c == 3)) begin
                errors++; $display("FAIL coll_valid c=%0d: got %b expected %b", c, out_valid, (c == 2 || c == 3));
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (out_pix !== exp[c-2]) begin errors++; $display("FAIL coll_pix c=%0d: got %h expected %h", c, out_pix, exp[c-2]); end
                checks++;
                if (pal_rdata !== exp[c-2]) begin errors++; $display("FAIL coll_rdata c=%0d: got %h expected %h", c, pal_rdata, exp[c-2]); end
            end
            tick();
        end
        pal_we = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_program();
        logic [11:0] pix [3];
        logic [11:0] exp [3];
        pix = '{12'h333, 12'h999, 12'h3C0};
        exp = '{12'hF00, 12'h0A5, 12'hF00};
        pal_we = 1'b1; pal_addr = 4'd3; pal_wdata = 12'hF00;
        tick();
        pal_addr = 4'd9; pal_wdata = 12'h0A5;
        tick();
        checks++;
        if (pal_rdata !== 12'h999) begin errors++; $display("FAIL prog_rdata_old: got %h expected 999", pal_rdata); end
        pal_we = 1'b0;
        tick();
        checks++;
        if (pal_rdata !== 12'h0A5) begin errors++; $display("FAIL prog_rdata_new: got %h expected 0a5", pal_rdata); end
        color_en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 3);
            if (c < 3) in_pix = pix[c];
            #1;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pix !== exp[c-2]) begin
                    errors++; $display("FAIL prog_pix c=%0d: got v=%b %h expected v=1 %h", c, out_valid, out_pix, exp[c-2]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bypass();
        logic [11:0] exp [2];
        exp = '{12'h1A7, 12'hFFF};
        pal_we = 1'b1; pal_addr = 4'd1; pal_wdata = 12'hFFF;
        tick();
        pal_we = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 2);
            in_pix   = 12'h1A7;
            color_en = (c == 1);
            #1;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pix !== exp[c-2]) begin
                    errors++; $display("FAIL bypass_pix c=%0d: got v=%b %h expected v=1 %h", c, out_valid, out_pix, exp[c-2]);
                end
            end
            tick();
        end
        in_valid = 1'b0; color_en = 1'b1;
    endtask

    task automatic test_midreset();
        pal_we = 1'b1; pal_addr = 4'd2; pal_wdata = 12'h00F;
        tick();
        pal_we = 1'b0; out_ready = 1'b0; color_en = 1'b1;
        in_valid = 1'b1; in_pix = 12'h222;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pix !== 12'h00F || in_ready !== 1'b0) begin
            errors++; $display("FAIL mr_pre: got v=%b %h rdy=%b expected v=1 00f rdy=0", out_valid, out_pix, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pix !== 12'h000) begin
            errors++; $display("FAIL mr_async: got v=%b %h expected v=0 000", out_valid, out_pix);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            in_pix   = 12'h222;
            #1;
            if (c == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pix !== 12'h222) begin
                    errors++; $display("FAIL mr_pix: got v=%b %h expected v=1 222", out_valid, out_pix);
                end
                checks++;
                if (pal_rdata !== 12'h222) begin errors++; $display("FAIL mr_rdata: got %h expected 222", pal_rdata); end
            end
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_drain: got %b expected 0", out_valid); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_colour();
        test_backpressure();
        test_collision();
        test_program();
        test_bypass();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
